// File: rtl/nmea_pkg.sv
// ---------------------------------------------------------------------------
// nmea_pkg
// Shared definitions for the NMEA feed controller: framing characters, the
// controller state encoding and an ASCII hex-digit decoder.
// ---------------------------------------------------------------------------
package nmea_pkg;

    localparam logic [7:0] CH_DOLLAR = 8'h24;  // sentence start '$'
    localparam logic [7:0] CH_STAR   = 8'h2A;  // checksum delimiter '*'
    localparam logic [7:0] CH_COMMA  = 8'h2C;  // field separator ','

    typedef enum logic [2:0] {
        HUNT,
        COLLECT,
        CK_HI,
        CK_LO,
        VERIFY,
        REPLAY,
        WAIT_DONE
    } ctrl_state_e;

    // Decodes one ASCII hex digit (0-9, A-F, a-f).
    // Returns {valid, nibble}; valid = 0 for any other byte.
    function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them to 10.
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

endpackage

// File: rtl/nmea_sent_buf.sv
// ---------------------------------------------------------------------------
// nmea_sent_buf
// Sentence byte store: synchronous write, combinational read, so the replay
// path can present a new byte every cycle without a read bubble.
//
// Ports:
//   clk    in   system clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data byte
//   raddr  in   read address
//   rdata  out  byte at raddr (combinational)
// ---------------------------------------------------------------------------
module nmea_sent_buf #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // NOTE: the storage array has no reset; the write pointer alone decides
    // which entries are meaningful, so stale contents are never replayed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nmea_feed_ctrl.sv
// ---------------------------------------------------------------------------
// nmea_feed_ctrl
// Captures one NMEA sentence ('$' ... '*hh') from the UART receiver, checks
// the XOR checksum and, only if it matches, replays '$' plus the stored body
// into the parser one byte per cycle. It then holds off new traffic until the
// parser signals completion or a timeout expires.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   rx_char      in   byte from UART receiver
//   rx_valid     in   rx_char strobe
//   parse_done   in   parser completion level, sampled in WAIT_DONE only
//   char         out  byte to parser
//   valid        out  char strobe during replay
//   busy         out  high in every state except HUNT
//   sentence_ok  out  pulse: checksum matched, replay starting
//   cksum_err    out  pulse: checksum mismatch or non-hex digit
//   overflow     out  pulse: sentence body exceeded the buffer
//   timeout      out  pulse: parser handshake abandoned
//   rx_drop      out  pulse: input byte discarded while busy with a sentence
// ---------------------------------------------------------------------------
module nmea_feed_ctrl
    import nmea_pkg::*;
#(
    parameter int BUF_DEPTH   = 128,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_char,
    input  logic       rx_valid,
    input  logic       parse_done,
    output logic [7:0] char,
    output logic       valid,
    output logic       busy,
    output logic       sentence_ok,
    output logic       cksum_err,
    output logic       overflow,
    output logic       timeout,
    output logic       rx_drop
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;                      // pointer counts 0..BUF_DEPTH
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] PTR_FULL = PW'(BUF_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    ctrl_state_e   state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;   // stored body length
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    xor_q, xor_d;         // running checksum of stored bytes
    logic [7:0]    ck_q, ck_d;           // checksum received after '*'
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic [7:0]    char_q, char_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          sentence_ok_q, sentence_ok_d;
    logic          cksum_err_q, cksum_err_d;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;
    logic          rx_drop_q, rx_drop_d;

    logic          buf_we;
    logic [7:0]    buf_rdata;
    logic [4:0]    hex_dec;

    assign hex_dec = hex_to_nibble(rx_char);

    nmea_sent_buf #(
        .DEPTH (BUF_DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (rx_char),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (buf_rdata)
    );

    // NOTE: every signal written below gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        xor_d         = xor_q;
        ck_d          = ck_q;
        tmo_cnt_d     = tmo_cnt_q;
        char_d        = 8'h00;
        valid_d       = 1'b0;
        sentence_ok_d = 1'b0;
        cksum_err_d   = 1'b0;
        overflow_d    = 1'b0;
        timeout_d     = 1'b0;
        buf_we        = 1'b0;

        case (state_q)
            HUNT: begin
                if (rx_valid && rx_char == CH_DOLLAR) begin
                    wr_ptr_d = '0;
                    xor_d    = '0;
                    state_d  = COLLECT;
                end
            end

            COLLECT: begin
                if (rx_valid) begin
                    if (rx_char == CH_DOLLAR) begin
                        wr_ptr_d = '0;
                        xor_d    = '0;
                    end else if (rx_char == CH_STAR) begin
                        state_d = CK_HI;
                    end else if (wr_ptr_q == PTR_FULL) begin
                        overflow_d = 1'b1;
                        state_d    = HUNT;
                    end else begin
                        buf_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        xor_d    = xor_q ^ rx_char;
                    end
                end
            end

            CK_HI, CK_LO: begin
                if (rx_valid) begin
                    if (rx_char == CH_DOLLAR) begin
                        wr_ptr_d = '0;
                        xor_d    = '0;
                        state_d  = COLLECT;
                    end else if (!hex_dec[4]) begin
                        cksum_err_d = 1'b1;
                        state_d     = HUNT;
                    end else if (state_q == CK_HI) begin
                        ck_d    = {hex_dec[3:0], ck_q[3:0]};
                        state_d = CK_LO;
                    end else begin
                        ck_d    = {ck_q[7:4], hex_dec[3:0]};
                        state_d = VERIFY;
                    end
                end
            end

            VERIFY: begin
                if (ck_q == xor_q) begin
                    // Replay opens with the '$' that was never stored.
                    sentence_ok_d = 1'b1;
                    rd_ptr_d      = '0;
                    char_d        = CH_DOLLAR;
                    valid_d       = 1'b1;
                    state_d       = REPLAY;
                end else begin
                    cksum_err_d = 1'b1;
                    state_d     = HUNT;
                end
            end

            REPLAY: begin
                if (rd_ptr_q != wr_ptr_q) begin
                    char_d   = buf_rdata;
                    valid_d  = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end else begin
                    tmo_cnt_d = '0;
                    state_d   = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (parse_done) begin
                    state_d = HUNT;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = HUNT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            default: state_d = HUNT;
        endcase

        // A discarded byte is always reported, even in the cycle that also
        // carries a sentence outcome pulse, so no input loss goes unseen.
        rx_drop_d = rx_valid && (state_q inside {VERIFY, REPLAY, WAIT_DONE});
        busy_d    = (state_d != HUNT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            xor_q         <= '0;
            ck_q          <= '0;
            tmo_cnt_q     <= '0;
            char_q        <= 8'h00;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            sentence_ok_q <= 1'b0;
            cksum_err_q   <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
            rx_drop_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            xor_q         <= xor_d;
            ck_q          <= ck_d;
            tmo_cnt_q     <= tmo_cnt_d;
            char_q        <= char_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            sentence_ok_q <= sentence_ok_d;
            cksum_err_q   <= cksum_err_d;
            overflow_q    <= overflow_d;
            timeout_q     <= timeout_d;
            rx_drop_q     <= rx_drop_d;
        end
    end

    assign char        = char_q;
    assign valid       = valid_q;
    assign busy        = busy_q;
    assign sentence_ok = sentence_ok_q;
    assign cksum_err   = cksum_err_q;
    assign overflow    = overflow_q;
    assign timeout     = timeout_q;
    assign rx_drop     = rx_drop_q;

endmodule
